// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan monitor: segment patterns (gfedcba, lit=1),
// capture FSM states and the decoded digit width.
// Hex letter patterns are always defined; whether they decode is chosen by SEG_HEX_DECODE_EN.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } seg_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose: maps a lit-high gfedcba segment pattern back to its digit (inverse of the BCD driver).
// Latency: combinational. Backpressure: none.
// SEG_HEX_DECODE_EN: when defined, A-F letter patterns decode as valid digits 0xA-0xF.
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0]         pattern,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid,
    output logic               illegal
);

    always_comb begin
        digit   = '0;
        valid   = 1'b1;
        illegal = 1'b0;
        case (pattern)
            SEG_0: digit = 4'h0;
            SEG_1: digit = 4'h1;
            SEG_2: digit = 4'h2;
            SEG_3: digit = 4'h3;
            SEG_4: digit = 4'h4;
            SEG_5: digit = 4'h5;
            SEG_6: digit = 4'h6;
            SEG_7: digit = 4'h7;
            SEG_8: digit = 4'h8;
            SEG_9: digit = 4'h9;
`ifdef SEG_HEX_DECODE_EN
            SEG_A: digit = 4'hA;
            SEG_B: digit = 4'hB;
            SEG_C: digit = 4'hC;
            SEG_D: digit = 4'hD;
            SEG_E: digit = 4'hE;
            SEG_F: digit = 4'hF;
`endif
            // A dark position is a legitimate display state, just not a digit.
            SEG_BLANK: valid = 1'b0;
            default: begin
                digit   = 4'hF;
                valid   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Purpose: monitors a multiplexed 7-seg bus (an/seg) and rebuilds each position's digit.
// Latency: pins stable from edge t are written at edge t+3+SETTLE_CYCLES. Backpressure: none.
// SEG_HEX_DECODE_EN (in seg7_pattern_decode) additionally accepts A-F patterns as digits.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_DIGITS-1:0]         an,
    input  logic [6:0]                  seg,
    input  logic [$clog2(N_DIGITS)-1:0] rd_idx,
    output logic [DIGIT_W-1:0]          rd_digit,
    output logic                        rd_valid,
    output logic [N_DIGITS-1:0]         digit_mask,
    output logic                        frame_done,
    output logic                        err,
    input  logic                        err_clr
);

    localparam int         IDX_W    = $clog2(N_DIGITS);
    localparam int         CNT_W    = IDX_W + 1;
    localparam logic       INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

    logic [N_DIGITS-1:0] an_meta;
    logic [N_DIGITS-1:0] an_sync;
    logic [6:0]          seg_meta;
    logic [6:0]          seg_sync;

    // Synchronizer idles at the pins' inactive level so reset looks like a dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_meta  <= {N_DIGITS{INACTIVE}};
            an_sync  <= {N_DIGITS{INACTIVE}};
            seg_meta <= {7{INACTIVE}};
            seg_sync <= {7{INACTIVE}};
        end else begin
            an_meta  <= an;
            an_sync  <= an_meta;
            seg_meta <= seg;
            seg_sync <= seg_meta;
        end
    end

    logic [N_DIGITS-1:0] an_act;
    logic [6:0]          seg_lit;

    assign an_act  = INACTIVE ? ~an_sync  : an_sync;
    assign seg_lit = INACTIVE ? ~seg_sync : seg_sync;

    logic [CNT_W-1:0] n_act;
    logic [IDX_W-1:0] smp_idx;

    always_comb begin
        n_act   = '0;
        smp_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (an_act[i]) begin
                n_act   = n_act + CNT_W'(1);
                smp_idx = IDX_W'(i);
            end
        end
    end

    seg_state_t       state;
    seg_state_t       state_nxt;
    logic [IDX_W-1:0] ref_idx;
    logic [6:0]       ref_seg;
    logic [7:0]       cnt;

    logic ev_one;
    logic ev_multi;
    logic same;
    logic rescan;
    logic load_ref;
    logic cnt_inc;
    logic anode_err;
    logic capture;

    assign ev_one   = (n_act == CNT_W'(1));
    assign ev_multi = (n_act > CNT_W'(1));
    assign same     = ev_one && (smp_idx == ref_idx) && (seg_lit == ref_seg);

    always_comb begin
        state_nxt = state;
        rescan    = 1'b0;
        load_ref  = 1'b0;
        cnt_inc   = 1'b0;
        anode_err = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: rescan = 1'b1;
            SETTLE: begin
                if (!same) begin
                    rescan = 1'b1;
                end else if (cnt >= SETTLE_N) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: rescan = !same;
            default: state_nxt = IDLE;
        endcase

        // Any change of the bus is judged as a fresh observation on the same cycle.
        if (rescan) begin
            if (ev_one) begin
                load_ref  = 1'b1;
                state_nxt = SETTLE;
            end else begin
                anode_err = ev_multi;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ref_idx <= '0;
            ref_seg <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (load_ref) begin
                ref_idx <= smp_idx;
                ref_seg <= seg_lit;
                cnt     <= 8'd1;
            end else if (cnt_inc) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_valid;
    logic               dec_illegal;

    seg7_pattern_decode u_decode (
        .pattern (ref_seg),
        .digit   (dec_digit),
        .valid   (dec_valid),
        .illegal (dec_illegal)
    );

    logic [DIGIT_W-1:0]  digit_q [N_DIGITS];
    logic [N_DIGITS-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (capture) begin
            digit_q[ref_idx] <= dec_digit;
            valid_q[ref_idx] <= dec_valid;
        end
    end

    assign rd_digit = digit_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    logic [N_DIGITS-1:0] cap_bit;

    assign cap_bit = capture ? (N_DIGITS'(1) << ref_idx) : '0;

    // A full mask restarts from empty, but a capture landing on that edge still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_mask <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= &digit_mask;
            digit_mask <= ((&digit_mask) ? '0 : digit_mask) | cap_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (anode_err || (capture && dec_illegal)) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display bus: watches the anode-select and segment lines that the display driver produces.
- Reconstructs the value shown on each of the 8 digit positions into an internal register file.
- Used as a bench/loopback monitor and for on-chip self-check of the display path.
- Flags segment patterns that do not decode to a legal digit.

Parameters:
- N_DIGITS, 8, number of anode positions; power of two, 2..8.
- SETTLE_CYCLES, 4, consecutive identical synchronized samples required before capture; range 1..255.
- ACTIVE_LOW, 1, 1 = anodes and segments are active-low on the pins; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- an  in  N_DIGITS  anode selects from the display bus
- seg  in  7  segment lines; bit0=a … bit6=g
- rd_idx  in  $clog2(N_DIGITS)  read address into the digit register file
- rd_digit  out  4  decoded value at rd_idx (combinational read)
- rd_valid  out  1  entry at rd_idx holds a legal digit
- digit_mask  out  N_DIGITS  bit i set = position i captured since the last frame_done
- frame_done  out  1  one-cycle pulse when every position has been captured
- err  out  1  sticky illegal-pattern or multi-anode flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- an and seg pass through a 2-FF synchronizer.
- Polarity is then normalised to 1 = active / lit when ACTIVE_LOW=1.
- Reset: FSM goes to IDLE.
  - All entries are digit=0, valid=0.
  - digit_mask=0, frame_done=0, err=0, settle counter=0, synchronizer flops = inactive level.
- FSM states:
  - IDLE:
    - Exactly one anode bit set: latch anode index and seg into ref registers, cnt=1, go to SETTLE.
    - Zero anodes: stay in IDLE.
    - More than one anode: set err, stay in IDLE.
  - SETTLE:
    - Sample equals ref (anode and seg): cnt++.
    - Sample differs: re-evaluate as in IDLE on that same cycle (reload ref, or return to IDLE).
    - cnt reaches SETTLE_CYCLES: go to CAPTURE.
  - CAPTURE (one cycle):
    - Decode ref seg and write the entry at the ref index.
    - Set digit_mask[idx] and go to HOLD.
  - HOLD:
    - Stay while the sample equals ref.
    - Any change: evaluate as in IDLE on that cycle.
- Decode table (gfedcba, lit=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 (blank): entry valid=0, digit=0, no error.
  - Any other pattern: valid=0, digit=0xF, err set.
- Latency: a pattern applied stably at the pins on edge t is written on edge t+2+SETTLE_CYCLES+1.
  - It is readable from rd_digit in the following cycle.
- Frame completion:
  - frame_done pulses on the cycle after digit_mask becomes all ones.
  - The same edge clears digit_mask to 0.
  - A capture on that same edge sets its bit in the fresh mask, so it is not lost.
- err_clr together with a new error on the same cycle: err stays 1 (set wins).
- Re-capturing a position overwrites its entry; there is no history.
- Asynchronous reset mid-SETTLE or mid-CAPTURE aborts without a partial write.
- With SETTLE_CYCLES=1: SETTLE lasts a single cycle.

Optional Feature:
- SEG_HEX_DECODE_EN
  - Defined: also decodes A=77, b=7C, C=39, d=5E, E=79, F=71 as valid digits 0xA–0xF.
  - Undefined: those patterns are illegal (valid=0, digit=0xF, err set).

Decomposition:
- Shared package seg_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK;
  - the state enum {IDLE, SETTLE, CAPTURE, HOLD};
  - DIGIT_W=4.
- One natural sub-module: seg7_pattern_decode.
  - Combinational: 7-bit pattern in; 4-bit digit, valid and illegal out.
  - It is the inverse of the team's BCD-to-segment driver.

Test Plan:
- Reset, then drive an=~8'h01, seg=~7'h06 for 10 cycles (ACTIVE_LOW=1) -> at edge 7 entry0 becomes digit=1, valid=1; digit_mask=8'h01.
- Scan positions 0..7 showing 0..7, 12 cycles each -> single frame_done pulse after position 7; digit_mask back to 0; rd_idx=5 reads 5.
- Glitch: seg changes after 2 stable cycles, then holds -> no capture of the first value; the second value is captured SETTLE_CYCLES later.
- Two anodes active (an=~8'h03) -> err=1, no write; err_clr -> err=0.
- seg=~7'h77 on position 2 -> without the macro: valid=0, digit=F, err=1; with SEG_HEX_DECODE_EN: digit=A, valid=1, err=0.
- Assert rst during SETTLE, then release -> all entries invalid, frame_done=0, FSM restarts from IDLE.
